// File: rtl/ex_stage.sv
// ex_stage: execute stage of the Ch0re 5-stage RV64I pipeline.
// Computes ALU results, effective addresses and link addresses, resolves
// branches/jumps into a redirect, and holds the result in EX/MEM.
// Optional build macro CH0RE_EX_FWD_EN enables operand forwarding from
// EX/MEM and MEM/WB plus load-use hazard stalling. The port list is the
// same in both builds.
module ex_stage #(
  parameter int XLEN           = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [XLEN-1:0]           i_pc,
  input  logic [6:0]                i_opcode,
  input  logic [2:0]                i_func3,
  input  logic [6:0]                i_func7,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd,
  input  logic [XLEN-1:0]           i_rs1,
  input  logic [XLEN-1:0]           i_rs2,
  input  logic [XLEN-1:0]           i_imm,
  input  logic                      i_flush,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [XLEN-1:0]           o_res,
  output logic [XLEN-1:0]           o_store_data,
  output logic [REG_ADDR_WIDTH-1:0] o_rd,
  output logic [2:0]                o_func3,
  output logic [6:0]                o_opcode,
  output logic                      o_wen,
  output logic                      o_redirect,
  output logic [XLEN-1:0]           o_redirect_pc,
  output logic                      o_exc,
  output logic [3:0]                o_exc_cause,
  input  logic                      i_wb_fwd_wen,
  input  logic [REG_ADDR_WIDTH-1:0] i_wb_fwd_rd,
  input  logic [XLEN-1:0]           i_wb_fwd_data,
  input  logic                      i_mem_ld_valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_mem_ld_rd
);

  localparam logic [6:0] OPC_LOAD    = 7'h03;
  localparam logic [6:0] OPC_OPIMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC   = 7'h17;
  localparam logic [6:0] OPC_OPIMM32 = 7'h1b;
  localparam logic [6:0] OPC_STORE   = 7'h23;
  localparam logic [6:0] OPC_OP      = 7'h33;
  localparam logic [6:0] OPC_LUI     = 7'h37;
  localparam logic [6:0] OPC_OP32    = 7'h3b;
  localparam logic [6:0] OPC_BRANCH  = 7'h63;
  localparam logic [6:0] OPC_JALR    = 7'h67;
  localparam logic [6:0] OPC_JAL     = 7'h6f;

  localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            hazard;
  logic            accept;

  // Only func7[5] (SUB/SRA select) is meaningful to this stage.
  logic unused_func7;
  assign unused_func7 = ^{i_func7[6], i_func7[4:0]};

`ifdef CH0RE_EX_FWD_EN
  logic ex_fwd_ok;
  assign ex_fwd_ok = o_valid && o_wen && (o_opcode != OPC_LOAD);

  // Operand select: EX/MEM result beats MEM/WB data beats the register file; x0 never forwards.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    rs1_val = i_rs1;
    rs2_val = i_rs2;
    if (i_rs1_addr != '0) begin
      if (ex_fwd_ok && (o_rd == i_rs1_addr))
        rs1_val = o_res;
      else if (i_wb_fwd_wen && (i_wb_fwd_rd == i_rs1_addr))
        rs1_val = i_wb_fwd_data;
    end
    if (i_rs2_addr != '0) begin
      if (ex_fwd_ok && (o_rd == i_rs2_addr))
        rs2_val = o_res;
      else if (i_wb_fwd_wen && (i_wb_fwd_rd == i_rs2_addr))
        rs2_val = i_wb_fwd_data;
    end
  end

  // Load-use stall: a source register is still being loaded in EX/MEM or MEM.
  always_comb begin
    hazard = 1'b0;
    if (i_valid) begin
      if ((i_rs1_addr != '0) &&
          ((o_valid && (o_opcode == OPC_LOAD) && (o_rd == i_rs1_addr)) ||
           (i_mem_ld_valid && (i_mem_ld_rd == i_rs1_addr))))
        hazard = 1'b1;
      if ((i_rs2_addr != '0) &&
          ((o_valid && (o_opcode == OPC_LOAD) && (o_rd == i_rs2_addr)) ||
           (i_mem_ld_valid && (i_mem_ld_rd == i_rs2_addr))))
        hazard = 1'b1;
    end
  end
`else
  assign rs1_val = i_rs1;
  assign rs2_val = i_rs2;
  assign hazard  = 1'b0;

  // Forwarding and hazard inputs are intentionally ignored in this build.
  logic unused_fwd;
  assign unused_fwd = ^{i_rs1_addr, i_rs2_addr, i_wb_fwd_wen, i_wb_fwd_rd,
                        i_wb_fwd_data, i_mem_ld_valid, i_mem_ld_rd};
`endif

  assign o_ready = (!o_valid || i_ready) && !hazard;
  assign accept  = i_valid && o_ready && !i_flush;

  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [31:0]     w_res;
  logic [31:0]     a32;
  logic [31:0]     b32;

  assign op_b = ((i_opcode == OPC_OP) || (i_opcode == OPC_OP32)) ? i_rs2 : i_imm;
  assign a32  = rs1_val[31:0];
  assign b32  = ((i_opcode == OPC_OP) || (i_opcode == OPC_OP32)) ? rs2_val[31:0] : i_imm[31:0];

  // 64-bit and 32-bit (W) integer ALU; func3 picks the operation.
  always_comb begin
    logic [XLEN-1:0] b;
    b       = ((i_opcode == OPC_OP) || (i_opcode == OPC_OP32)) ? rs2_val : op_b;
    alu_res = '0;
    w_res   = '0;
    case (i_func3)
      3'd0: alu_res = ((i_opcode == OPC_OP) && i_func7[5]) ? rs1_val - b : rs1_val + b;
      3'd1: alu_res = rs1_val << b[5:0];
      3'd2: alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(b))};
      3'd3: alu_res = {{(XLEN-1){1'b0}}, (rs1_val < b)};
      3'd4: alu_res = rs1_val ^ b;
      3'd5: alu_res = i_func7[5] ? XLEN'($signed(rs1_val) >>> b[5:0]) : rs1_val >> b[5:0];
      3'd6: alu_res = rs1_val | b;
      default: alu_res = rs1_val & b;
    endcase
    case (i_func3)
      3'd0: w_res = ((i_opcode == OPC_OP32) && i_func7[5]) ? a32 - b32 : a32 + b32;
      3'd1: w_res = a32 << b32[4:0];
      3'd5: w_res = i_func7[5] ? 32'($signed(a32) >>> b32[4:0]) : a32 >> b32[4:0];
      default: w_res = '0;
    endcase
  end

  logic br_taken;

  // Branch condition evaluation on forwarded operands.
  always_comb begin
    case (i_func3)
      3'd0:    br_taken = (rs1_val == rs2_val);
      3'd1:    br_taken = (rs1_val != rs2_val);
      3'd4:    br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'd5:    br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'd6:    br_taken = (rs1_val <  rs2_val);
      3'd7:    br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  logic [XLEN-1:0] res_d;
  logic [XLEN-1:0] target_d;
  logic [XLEN-1:0] jalr_sum;
  logic            wen_d;
  logic            redirect_d;
  logic            exc_d;
  logic [3:0]      cause_d;

  assign jalr_sum = rs1_val + i_imm;

  // Per-opcode result, writeback, redirect and exception decode.
  always_comb begin
    logic jump;
    res_d      = '0;
    target_d   = '0;
    wen_d      = 1'b0;
    redirect_d = 1'b0;
    exc_d      = 1'b0;
    cause_d    = '0;
    jump       = 1'b0;
    // Every legal opcode ends in 2'b11, so a bad low pair falls to default.
    case (i_opcode)
      OPC_OP, OPC_OPIMM: begin
        res_d = alu_res;
        wen_d = 1'b1;
      end
      OPC_OP32, OPC_OPIMM32: begin
        res_d = {{(XLEN-32){w_res[31]}}, w_res};
        wen_d = 1'b1;
      end
      OPC_LUI: begin
        res_d = i_imm;
        wen_d = 1'b1;
      end
      OPC_AUIPC: begin
        res_d = i_pc + i_imm;
        wen_d = 1'b1;
      end
      OPC_LOAD: begin
        res_d = jalr_sum;
        wen_d = 1'b1;
      end
      OPC_STORE: res_d = jalr_sum;
      OPC_JAL: begin
        res_d    = i_pc + XLEN'(4);
        target_d = i_pc + i_imm;
        jump     = 1'b1;
        wen_d    = 1'b1;
      end
      OPC_JALR: begin
        res_d    = i_pc + XLEN'(4);
        target_d = {jalr_sum[XLEN-1:1], 1'b0};
        jump     = 1'b1;
        wen_d    = 1'b1;
      end
      OPC_BRANCH: begin
        target_d = i_pc + i_imm;
        jump     = br_taken;
      end
      default: begin
        exc_d   = 1'b1;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase
    if (jump) begin
      if (target_d[1:0] != 2'b00) begin
        exc_d   = 1'b1;
        cause_d = CAUSE_MISALIGNED;
      end else begin
        redirect_d = 1'b1;
      end
    end
    if (exc_d || (i_rd == '0))
      wen_d = 1'b0;
  end

  // EX/MEM pipeline register: flush beats accept, a drained slot goes invalid.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      o_valid       <= 1'b0;
      o_res         <= '0;
      o_store_data  <= '0;
      o_rd          <= '0;
      o_func3       <= '0;
      o_opcode      <= '0;
      o_wen         <= 1'b0;
      o_redirect    <= 1'b0;
      o_redirect_pc <= '0;
      o_exc         <= 1'b0;
      o_exc_cause   <= '0;
    end else if (i_flush) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      o_valid    <= 1'b0;
      o_redirect <= 1'b0;
    end else if (accept) begin
      o_valid       <= 1'b1;
      o_res         <= res_d;
      o_store_data  <= rs2_val;
      o_rd          <= i_rd;
      o_func3       <= i_func3;
      o_opcode      <= i_opcode;
      o_wen         <= wen_d;
      o_redirect    <= redirect_d;
      o_redirect_pc <= target_d;
      o_exc         <= exc_d;
      o_exc_cause   <= cause_d;
    end else if (i_ready) begin
      o_valid    <= 1'b0;
      o_redirect <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: table-driven directed vectors for ex_stage plus hand-written
// sequences for stall, flush, asynchronous reset and (when built with
// CH0RE_EX_FWD_EN) forwarding / load-use corner cases.
module tb_ex_stage;

  logic        clk;
  logic        rst_;
  logic        i_valid;
  logic        o_ready;
  logic [63:0] i_pc;
  logic [6:0]  i_opcode;
  logic [2:0]  i_func3;
  logic [6:0]  i_func7;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic [4:0]  i_rd;
  logic [63:0] i_rs1;
  logic [63:0] i_rs2;
  logic [63:0] i_imm;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_res;
  logic [63:0] o_store_data;
  logic [4:0]  o_rd;
  logic [2:0]  o_func3;
  logic [6:0]  o_opcode;
  logic        o_wen;
  logic        o_redirect;
  logic [63:0] o_redirect_pc;
  logic        o_exc;
  logic [3:0]  o_exc_cause;
  logic        i_wb_fwd_wen;
  logic [4:0]  i_wb_fwd_rd;
  logic [63:0] i_wb_fwd_data;
  logic        i_mem_ld_valid;
  logic [4:0]  i_mem_ld_rd;

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk(clk), .rst_(rst_), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_opcode(i_opcode), .i_func3(i_func3), .i_func7(i_func7),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rd(i_rd),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_res(o_res),
    .o_store_data(o_store_data), .o_rd(o_rd), .o_func3(o_func3),
    .o_opcode(o_opcode), .o_wen(o_wen), .o_redirect(o_redirect),
    .o_redirect_pc(o_redirect_pc), .o_exc(o_exc), .o_exc_cause(o_exc_cause),
    .i_wb_fwd_wen(i_wb_fwd_wen), .i_wb_fwd_rd(i_wb_fwd_rd),
    .i_wb_fwd_data(i_wb_fwd_data), .i_mem_ld_valid(i_mem_ld_valid),
    .i_mem_ld_rd(i_mem_ld_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [63:0] pc;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic        chk_res;
    logic [63:0] res;
    logic        wen;
    logic        redir;
    logic [63:0] rpc;
    logic        exc;
    logic [3:0]  cause;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [63:0] pc, input logic [6:0] opc,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [63:0] rs1,
                              input logic [63:0] rs2, input logic [63:0] imm,
                              input logic chk_res, input logic [63:0] res,
                              input logic wen, input logic redir,
                              input logic [63:0] rpc, input logic exc,
                              input logic [3:0] cause);
    vec_t v;
    v.pc = pc; v.opc = opc; v.f3 = f3; v.f7 = f7; v.rd = rd;
    v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.chk_res = chk_res;
    v.res = res; v.wen = wen; v.redir = redir; v.rpc = rpc;
    v.exc = exc; v.cause = cause;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [63:0] pc, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd,
                       input logic [4:0] ra1, input logic [63:0] rs1,
                       input logic [4:0] ra2, input logic [63:0] rs2,
                       input logic [63:0] imm);
    i_pc = pc; i_opcode = opc; i_func3 = f3; i_func7 = f7; i_rd = rd;
    i_rs1_addr = ra1; i_rs1 = rs1; i_rs2_addr = ra2; i_rs2 = rs2; i_imm = imm;
  endtask

  // Present one instruction for a single accepting edge, then sample.
  task automatic issue(input vec_t v);
    @(negedge clk);
    drive(v.pc, v.opc, v.f3, v.f7, v.rd, 5'd0, v.rs1, 5'd0, v.rs2, v.imm);
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    rst_ = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_flush = 1'b0;
    drive(64'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 64'd0, 5'd0, 64'd0, 64'd0);
    i_wb_fwd_wen = 1'b0; i_wb_fwd_rd = '0; i_wb_fwd_data = '0;
    i_mem_ld_valid = 1'b0; i_mem_ld_rd = '0;

    #12;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_res", o_res, 64'd0);
    check("rst_redirect", 64'(o_redirect), 64'd0);
    check("rst_exc", 64'(o_exc), 64'd0);
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    check("post_rst_ready", 64'(o_ready), 64'd1);

    //         pc        opc    f3    f7     rd  rs1                    rs2                    imm                    cr res                     wen redir rpc        exc cause
    vecs.push_back(mk(64'h0,   7'h13, 3'd0, 7'h00, 6, 64'd0,                 64'd0,                 64'd1,                 1, 64'd1,                  1, 0, 64'd0,      0, 0)); // addi x6,x0,1
    vecs.push_back(mk(64'h0,   7'h3b, 3'd0, 7'h00, 7, 64'h7FFF_FFFF,         64'd1,                 64'd0,                 1, 64'hFFFF_FFFF_8000_0000,1, 0, 64'd0,      0, 0)); // addw
    vecs.push_back(mk(64'h0,   7'h13, 3'd5, 7'h20, 8, 64'h8000_0000_0000_0000, 64'd0,               64'h43F,               1, ONES,                   1, 0, 64'd0,      0, 0)); // srai 63
    vecs.push_back(mk(64'h0,   7'h33, 3'd0, 7'h20, 9, 64'd5,                 64'd7,                 64'd0,                 1, 64'hFFFF_FFFF_FFFF_FFFE,1, 0, 64'd0,      0, 0)); // sub
    vecs.push_back(mk(64'h0,   7'h33, 3'd2, 7'h00, 9, ONES,                  64'd1,                 64'd0,                 1, 64'd1,                  1, 0, 64'd0,      0, 0)); // slt
    vecs.push_back(mk(64'h0,   7'h33, 3'd3, 7'h00, 9, 64'd1,                 ONES,                  64'd0,                 1, 64'd1,                  1, 0, 64'd0,      0, 0)); // sltu
    vecs.push_back(mk(64'h0,   7'h3b, 3'd1, 7'h00, 9, 64'd1,                 64'h3F,                64'd0,                 1, 64'hFFFF_FFFF_8000_0000,1, 0, 64'd0,      0, 0)); // sllw
    vecs.push_back(mk(64'h0,   7'h3b, 3'd5, 7'h00, 9, 64'hFFFF_FFFF_8000_0000, 64'd4,               64'd0,                 1, 64'h0800_0000,          1, 0, 64'd0,      0, 0)); // srlw
    vecs.push_back(mk(64'h0,   7'h33, 3'd5, 7'h20, 9, 64'hFFFF_FFFF_FFFF_FFF0, 64'h42,              64'd0,                 1, 64'hFFFF_FFFF_FFFF_FFFC,1, 0, 64'd0,      0, 0)); // sra
    vecs.push_back(mk(64'h0,   7'h33, 3'd1, 7'h00, 9, 64'd1,                 64'd63,                64'd0,                 1, 64'h8000_0000_0000_0000,1, 0, 64'd0,      0, 0)); // sll
    vecs.push_back(mk(64'h0,   7'h33, 3'd7, 7'h00, 9, 64'hF0F0,              64'hFF00,              64'd0,                 1, 64'hF000,               1, 0, 64'd0,      0, 0)); // and
    vecs.push_back(mk(64'h0,   7'h33, 3'd6, 7'h00, 9, 64'hF0F0,              64'hFF00,              64'd0,                 1, 64'hFFF0,               1, 0, 64'd0,      0, 0)); // or
    vecs.push_back(mk(64'h0,   7'h33, 3'd0, 7'h00, 9, ONES,                  64'd1,                 64'd0,                 1, 64'd0,                  1, 0, 64'd0,      0, 0)); // add wrap
    vecs.push_back(mk(64'h0,   7'h13, 3'd0, 7'h00, 0, 64'd2,                 64'd0,                 64'd3,                 1, 64'd5,                  0, 0, 64'd0,      0, 0)); // addi x0
    vecs.push_back(mk(64'h0,   7'h37, 3'd0, 7'h00, 3, 64'h55,                64'd0,                 64'h1234_5000,         1, 64'h1234_5000,          1, 0, 64'd0,      0, 0)); // lui
    vecs.push_back(mk(64'h1000,7'h17, 3'd0, 7'h00, 3, 64'd0,                 64'd0,                 64'h2000,              1, 64'h3000,               1, 0, 64'd0,      0, 0)); // auipc
    vecs.push_back(mk(64'h0,   7'h03, 3'd3, 7'h00, 5, 64'h100,               64'd0,                 64'hFFFF_FFFF_FFFF_FFF8,1, 64'hF8,                1, 0, 64'd0,      0, 0)); // ld
    vecs.push_back(mk(64'h0,   7'h23, 3'd3, 7'h00, 9, 64'h200,               64'hDEAD,              64'h10,                1, 64'h210,                0, 0, 64'd0,      0, 0)); // sd
    vecs.push_back(mk(64'h100, 7'h6f, 3'd0, 7'h00, 1, 64'd0,                 64'd0,                 64'h40,                1, 64'h104,                1, 1, 64'h140,    0, 0)); // jal
    vecs.push_back(mk(64'h200, 7'h67, 3'd0, 7'h00, 1, 64'h301,               64'd0,                 64'd0,                 1, 64'h204,                1, 1, 64'h300,    0, 0)); // jalr
    vecs.push_back(mk(64'h300, 7'h67, 3'd0, 7'h00, 1, 64'h100,               64'd0,                 64'd2,                 0, 64'd0,                  0, 0, 64'd0,      1, 0)); // jalr misaligned
    vecs.push_back(mk(64'h100, 7'h63, 3'd0, 7'h00, 3, 64'd5,                 64'd5,                 64'h20,                0, 64'd0,                  0, 1, 64'h120,    0, 0)); // beq taken
    vecs.push_back(mk(64'h100, 7'h63, 3'd1, 7'h00, 3, 64'd5,                 64'd5,                 64'h20,                0, 64'd0,                  0, 0, 64'd0,      0, 0)); // bne not taken
    vecs.push_back(mk(64'h100, 7'h63, 3'd4, 7'h00, 3, ONES,                  64'd1,                 64'hFFFF_FFFF_FFFF_FFF0,0, 64'd0,                 0, 1, 64'hF0,     0, 0)); // blt taken
    vecs.push_back(mk(64'h200, 7'h63, 3'd7, 7'h00, 3, ONES,                  64'd1,                 64'd8,                 0, 64'd0,                  0, 1, 64'h208,    0, 0)); // bgeu taken
    vecs.push_back(mk(64'h200, 7'h63, 3'd6, 7'h00, 3, ONES,                  64'd1,                 64'd8,                 0, 64'd0,                  0, 0, 64'd0,      0, 0)); // bltu not taken
    vecs.push_back(mk(64'h100, 7'h63, 3'd0, 7'h00, 3, 64'd5,                 64'd5,                 64'd6,                 0, 64'd0,                  0, 0, 64'd0,      1, 0)); // beq misaligned
    vecs.push_back(mk(64'h0,   7'h7f, 3'd0, 7'h00, 4, 64'd1,                 64'd1,                 64'd1,                 0, 64'd0,                  0, 0, 64'd0,      1, 2)); // illegal
    vecs.push_back(mk(64'h0,   7'h32, 3'd0, 7'h00, 4, 64'd1,                 64'd1,                 64'd1,                 0, 64'd0,                  0, 0, 64'd0,      1, 2)); // low bits 10

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i]);
      check($sformatf("v%0d_valid", i), 64'(o_valid), 64'd1);
      if (vecs[i].chk_res) check($sformatf("v%0d_res", i), o_res, vecs[i].res);
      check($sformatf("v%0d_rd", i), 64'(o_rd), 64'(vecs[i].rd));
      check($sformatf("v%0d_opcode", i), 64'(o_opcode), 64'(vecs[i].opc));
      check($sformatf("v%0d_wen", i), 64'(o_wen), 64'(vecs[i].wen));
      check($sformatf("v%0d_redirect", i), 64'(o_redirect), 64'(vecs[i].redir));
      if (vecs[i].redir) check($sformatf("v%0d_rpc", i), o_redirect_pc, vecs[i].rpc);
      check($sformatf("v%0d_exc", i), 64'(o_exc), 64'(vecs[i].exc));
      if (vecs[i].exc) check($sformatf("v%0d_cause", i), 64'(o_exc_cause), 64'(vecs[i].cause));
      if (vecs[i].opc == 7'h23) check($sformatf("v%0d_store_data", i), o_store_data, vecs[i].rs2);
    end

    // Redirect lasts only while the instruction is valid.
    @(posedge clk); #1;
    check("drain_valid", 64'(o_valid), 64'd0);
    check("drain_redirect", 64'(o_redirect), 64'd0);

    // Backpressure: hold the result for 3 cycles, then release.
    @(negedge clk);
    drive(64'h0, 7'h13, 3'd0, 7'h00, 5'd6, 5'd0, 64'd0, 5'd0, 64'd0, 64'h11);
    i_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    i_ready = 1'b0;
    drive(64'h0, 7'h33, 3'd0, 7'h00, 5'd7, 5'd0, 64'd2, 5'd0, 64'd3, 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d_ready", c), 64'(o_ready), 64'd0);
      check($sformatf("stall%0d_valid", c), 64'(o_valid), 64'd1);
      check($sformatf("stall%0d_res", c), o_res, 64'h11);
      check($sformatf("stall%0d_rd", c), 64'(o_rd), 64'd6);
    end
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("release_res", o_res, 64'd5);
    check("release_rd", 64'(o_rd), 64'd7);

    // Flush beats accept even when the stage is ready.
    @(negedge clk);
    drive(64'h0, 7'h13, 3'd0, 7'h00, 5'd9, 5'd0, 64'd0, 5'd0, 64'd0, 64'd9);
    i_valid = 1'b1;
    i_flush = 1'b1;
    @(posedge clk); #1;
    check("flush_valid", 64'(o_valid), 64'd0);
    @(negedge clk);
    i_flush = 1'b0;
    i_valid = 1'b0;
    @(posedge clk); #1;
    check("flush_not_consumed", 64'(o_valid), 64'd0);

`ifdef CH0RE_EX_FWD_EN
    // EX/MEM forwarding: addi x5=7 then add x6,x5,x5 with stale operands.
    @(negedge clk);
    drive(64'h0, 7'h13, 3'd0, 7'h00, 5'd5, 5'd0, 64'd0, 5'd0, 64'd0, 64'd7);
    i_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    drive(64'h0, 7'h33, 3'd0, 7'h00, 5'd6, 5'd5, 64'd0, 5'd5, 64'd0, 64'd0);
    @(posedge clk); #1;
    check("fwd_ex_res", o_res, 64'd14);
    // EX/MEM wins over MEM/WB for the same register.
    @(negedge clk);
    drive(64'h0, 7'h33, 3'd0, 7'h00, 5'd7, 5'd6, 64'd0, 5'd0, 64'd0, 64'd0);
    i_wb_fwd_wen = 1'b1; i_wb_fwd_rd = 5'd6; i_wb_fwd_data = 64'd100;
    @(posedge clk); #1;
    check("fwd_priority_res", o_res, 64'd14);
    // MEM/WB forwarding alone.
    @(negedge clk);
    drive(64'h0, 7'h33, 3'd0, 7'h00, 5'd8, 5'd3, 64'd0, 5'd0, 64'd0, 64'd0);
    i_wb_fwd_rd = 5'd3; i_wb_fwd_data = 64'h55;
    @(posedge clk); #1;
    check("fwd_wb_res", o_res, 64'h55);
    // x0 never forwards.
    @(negedge clk);
    drive(64'h0, 7'h33, 3'd0, 7'h00, 5'd8, 5'd0, 64'd3, 5'd0, 64'd0, 64'd0);
    i_wb_fwd_rd = 5'd0; i_wb_fwd_data = 64'h99;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_wb_fwd_wen = 1'b0;
    check("fwd_x0_res", o_res, 64'd3);
    // Load-use: ld x5 then add x6,x5,x0.
    @(negedge clk);
    drive(64'h0, 7'h03, 3'd3, 7'h00, 5'd5, 5'd0, 64'h1000, 5'd0, 64'd0, 64'd0);
    i_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    drive(64'h0, 7'h33, 3'd0, 7'h00, 5'd6, 5'd5, 64'd0, 5'd0, 64'd0, 64'd0);
    #1;
    check("lu_ex_ready", 64'(o_ready), 64'd0);
    @(posedge clk); #1;
    check("lu_ex_valid", 64'(o_valid), 64'd0);
    @(negedge clk);
    i_mem_ld_valid = 1'b1; i_mem_ld_rd = 5'd5;
    #1;
    check("lu_mem_ready", 64'(o_ready), 64'd0);
    @(posedge clk); #1;
    check("lu_mem_valid", 64'(o_valid), 64'd0);
    @(negedge clk);
    i_mem_ld_valid = 1'b0;
    i_wb_fwd_wen = 1'b1; i_wb_fwd_rd = 5'd5; i_wb_fwd_data = 64'h77;
    #1;
    check("lu_wb_ready", 64'(o_ready), 64'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("lu_wb_valid", 64'(o_valid), 64'd1);
    check("lu_wb_res", o_res, 64'h77);
    @(negedge clk);
    i_wb_fwd_wen = 1'b0;
`else
    // Forwarding/hazard ports are ignored in the default build.
    @(negedge clk);
    drive(64'h0, 7'h03, 3'd3, 7'h00, 5'd5, 5'd0, 64'h1000, 5'd0, 64'd0, 64'd0);
    i_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    drive(64'h0, 7'h33, 3'd0, 7'h00, 5'd6, 5'd5, 64'd3, 5'd0, 64'd4, 64'd0);
    i_mem_ld_valid = 1'b1; i_mem_ld_rd = 5'd5;
    i_wb_fwd_wen = 1'b1; i_wb_fwd_rd = 5'd5; i_wb_fwd_data = 64'h99;
    #1;
    check("nofwd_ready", 64'(o_ready), 64'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("nofwd_res", o_res, 64'd7);
    @(negedge clk);
    i_mem_ld_valid = 1'b0; i_wb_fwd_wen = 1'b0;
`endif

    // Asynchronous reset while a redirecting jump is stalled.
    @(negedge clk);
    drive(64'h400, 7'h6f, 3'd0, 7'h00, 5'd1, 5'd0, 64'd0, 5'd0, 64'd0, 64'h10);
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    check("pre_rst_redirect", 64'(o_redirect), 64'd1);
    #2;
    rst_ = 1'b0;
    #1;
    check("arst_valid", 64'(o_valid), 64'd0);
    check("arst_res", o_res, 64'd0);
    check("arst_rd", 64'(o_rd), 64'd0);
    check("arst_wen", 64'(o_wen), 64'd0);
    check("arst_redirect", 64'(o_redirect), 64'd0);
    check("arst_rpc", o_redirect_pc, 64'd0);
    @(negedge clk);
    rst_ = 1'b1;
    i_ready = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the Ch0re 5-stage RV64I pipeline, between the ID/EX and MEM stages. Accepts one decoded instruction per cycle over a valid/ready handshake and computes the ALU result, load/store address, or link address. Resolves branches and jumps into a redirect, and holds the result in the EX/MEM pipeline register. When configured, it also forwards operands from EX/MEM and MEM/WB and stalls on load-use hazards.

## Interface
- XLEN, 64: datapath width; only 64 is supported.
- REG_ADDR_WIDTH, 5: register index width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_  in  1  reset, asynchronous, active-low; clock clk.
- i_valid / o_ready  in / out  1  upstream handshake; an instruction is accepted when both are high.
- i_pc  in  64  PC of the instruction.
- i_opcode, i_func3, i_func7  in  7, 3, 7  decoded instruction fields.
- i_rs1_addr, i_rs2_addr, i_rd  in  5 each  source and destination register indices.
- i_rs1, i_rs2, i_imm  in  64 each  register-file operands and the sign-extended immediate.
- i_flush  in  1  kills the instruction in the EX/MEM register and blocks acceptance this cycle.
- o_valid / i_ready  out / in  1  downstream handshake.
- o_res  out  64  ALU result, effective address, or link address.
- o_store_data  out  64  forwarded rs2 value.
- o_rd, o_func3, o_opcode  out  5, 3, 7  passed to MEM and WB.
- o_wen  out  1  register writeback required; always 0 when o_rd is 0.
- o_redirect, o_redirect_pc  out  1, 64  branch/jump redirect, qualified by o_valid.
- o_exc, o_exc_cause  out  1, 4  exception flag and cause: 0 = instruction-address-misaligned, 2 = illegal instruction.
- i_wb_fwd_wen, i_wb_fwd_rd, i_wb_fwd_data  in  1, 5, 64  MEM/WB writeback, used for forwarding.
- i_mem_ld_valid, i_mem_ld_rd  in  1, 5  a load currently in the MEM stage.

## Operation
- Acceptance rule: o_ready = (!o_valid || i_ready) && !hazard.
- On accept, the EX/MEM register loads the computed fields and o_valid goes to 1.
- On a downstream transfer with no new accept, o_valid goes to 0.
- i_flush has priority over accept: o_valid goes to 0 and the input is not consumed.
- OP and OP-IMM (0x33, 0x13): ADD, SUB (func7[5], OP only), SLL, SLT, SLTU, XOR, SRL, SRA (func7[5]), OR, AND.
  - Shift amount is bits [5:0] of the second operand.
- OP-32 and OP-IMM-32 (0x3b, 0x1b): ADDW, SUBW, SLLW, SRLW, SRAW.
  - Operate on bits [31:0] with a shift amount of bits [4:0], then sign-extend bit 31 to 64 bits.
- LUI: o_res = imm. AUIPC: o_res = pc + imm.
- LOAD and STORE (0x03, 0x23): o_res = rs1 + imm, and o_store_data = rs2.
  - o_wen is 1 for LOAD and 0 for STORE.
- JAL: o_res = pc + 4 and target = pc + imm. JALR: o_res = pc + 4 and target = (rs1 + imm) & ~1.
  - Both set o_redirect = 1.
- BRANCH (0x63), func3 selects BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - Taken: redirect to pc + imm. Not taken: no redirect.
  - o_wen = 0.
- A target with bits [1:0] != 0 (IALIGN = 32) sets o_exc with cause 0; o_redirect = 0 and o_wen = 0.
- Any other opcode, or i_opcode[1:0] != 2'b11, sets o_exc with cause 2 and o_wen = 0.
- All arithmetic wraps modulo 2^64. There is no overflow trap.

## Timing
- Reset value of every output register is 0; o_ready is 1 once reset is deasserted.
- Latency is 1 cycle from accept to o_valid, sustaining 1 instruction per cycle when i_ready is held at 1.
- While o_valid && !i_ready, all outputs hold stable.
- o_redirect is asserted for exactly the cycles the redirecting instruction is valid in EX/MEM. Upstream flushes on it.
- Asserting rst_ mid-stall drops o_valid immediately and asynchronously; the held instruction is lost.

## Configuration
- Macro CH0RE_EX_FWD_EN.
- Defined: operand priority for rs1 and rs2 is, highest first:
  1. EX/MEM register, when o_valid && o_wen && o_opcode != LOAD && o_rd matches.
  2. MEM/WB input, when i_wb_fwd_wen && the rd matches.
  3. i_rs1 / i_rs2.
- Register x0 is never forwarded.
- hazard = i_valid && the source index != 0 && the source matches either:
  - (o_valid && o_opcode == LOAD && o_rd), or
  - (i_mem_ld_valid && i_mem_ld_rd).
- Undefined: operands come only from i_rs1 / i_rs2, hazard = 0, and the forwarding ports are ignored.
  - The port list is identical in both builds.

## Test plan
- Reset, then addi x6,x0,1 (imm 1, rs1 0) -> next cycle o_valid=1, o_res=1, o_rd=6, o_wen=1.
- ADDW with rs1=0x7FFFFFFF and rs2=1 -> o_res=0xFFFFFFFF80000000. SRAI with rs1=0x8000000000000000, shamt 63 -> o_res=all ones.
- BEQ with rs1==rs2, pc=0x100, imm=0x20 -> o_redirect=1, o_redirect_pc=0x120, o_wen=0. JALR with target 0x102 -> o_exc=1, o_exc_cause=0, no redirect.
- Hold i_ready=0 for 3 cycles while the output is valid -> o_ready=0 and outputs stable. Assert i_flush -> o_valid=0 next cycle.
- With CH0RE_EX_FWD_EN: addi x5=7, then add x6,x5,x5 with stale i_rs1=0 -> o_res=14.
  - ld x5 followed by a dependent add -> o_ready=0 until the load leaves MEM, then the result uses i_wb_fwd_data.
- Opcode 7'h7F -> o_exc=1, o_exc_cause=2, o_wen=0. Assert rst_ mid-stall -> all outputs 0 asynchronously.
